// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, single-outstanding read, decode handoff
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instu,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [63:0] kill_pc_q, kill_pc_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  // Low until the first edge after reset release: no request has been driven
  // yet, so any stale data_ok from before the reset must not be sampled.
  logic        started_q;

  logic [63:0] redir_pc;

  // Redirect targets are always word aligned.
  assign redir_pc = {redirect_pc[63:2], 2'b00};

  // State register; asynchronous clear puts the stage back at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      kill_pc_q   <= RESET_PC;
      instr_buf_q <= 32'h0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      kill_pc_q   <= kill_pc_d;
      instr_buf_q <= instr_buf_d;
      started_q   <= 1'b1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    kill_pc_d   = kill_pc_q;
    instr_buf_d = instr_buf_q;
    ireq_valid  = 1'b0;
    if_valid    = 1'b0;

    case (state_q)
      S_REQ: begin
        ireq_valid = started_q;
        if (!started_q) begin
          // Nothing in flight yet, so a redirect can retarget the PC directly.
          if (redirect_valid) begin
            pc_d = redir_pc;
          end
        end else if (iresp_data_ok) begin
          kill_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redir_pc;
          end else if (kill_q) begin
            pc_d = kill_pc_q;
          end else begin
            instr_buf_d = iresp_data;
            state_d     = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Keep the bus address stable; remember where to go once the
          // wrong-path word comes back. Later redirects overwrite the target.
          kill_d    = 1'b1;
          kill_pc_d = redir_pc;
        end
      end

      S_HOLD: begin
        if_valid = ~redirect_valid;
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign ireq_addr = pc_q;
  assign if_pc     = pc_q;
  assign if_instu  = instr_buf_q;

`ifndef SYNTHESIS
  // Bus address and request must hold until the memory answers.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (ireq_valid && !iresp_data_ok) |=> (ireq_valid && $stable(ireq_addr)));

  // Requesting and offering to decode are mutually exclusive.
  a_one_role: assert property (@(posedge clk) disable iff (!rst_n)
    !(ireq_valid && if_valid));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instu;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int n_checks;
  int n_errors;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instu       (if_instu),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;

    // Reset state
    tick();
    tick();
    chk("rst_ireq_valid", {63'h0, ireq_valid}, 64'd0);
    chk("rst_if_valid",   {63'h0, if_valid}, 64'd0);
    chk("rst_if_pc",      if_pc, RST_PC);
    chk("rst_if_instu",   {32'h0, if_instu}, 64'h0);

    // 1: first fetch, one-cycle memory
    rst_n = 1'b1;
    tick();
    chk("t1_ireq_valid", {63'h0, ireq_valid}, 64'd1);
    chk("t1_ireq_addr",  ireq_addr, 64'h8000_0000);
    tick();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0050_0093;
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t1_if_valid", {63'h0, if_valid}, 64'd1);
    chk("t1_if_pc",    if_pc, 64'h8000_0000);
    chk("t1_if_instu", {32'h0, if_instu}, 64'h0050_0093);

    // 2: decode stalls for five cycles, then accepts
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", {63'h0, if_valid}, 64'd1);
      chk("t2_hold_pc",    if_pc, 64'h8000_0000);
      chk("t2_hold_instu", {32'h0, if_instu}, 64'h0050_0093);
      chk("t2_hold_noreq", {63'h0, ireq_valid}, 64'd0);
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    #1;
    chk("t2_next_req",  {63'h0, ireq_valid}, 64'd1);
    chk("t2_next_addr", ireq_addr, 64'h8000_0004);
    chk("t2_no_valid",  {63'h0, if_valid}, 64'd0);

    // 3: redirect while the request to 0x8000_0004 is pending
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    #1;
    chk("t3_addr_redir_cyc", ireq_addr, 64'h8000_0004);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_addr_held1", ireq_addr, 64'h8000_0004);
    tick();
    chk("t3_addr_held2", ireq_addr, 64'h8000_0004);
    tick();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hdead_beef;
    #1;
    chk("t3_addr_held3", ireq_addr, 64'h8000_0004);
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t3_dropped",  {63'h0, if_valid}, 64'd0);
    chk("t3_new_req",  {63'h0, ireq_valid}, 64'd1);
    chk("t3_new_addr", ireq_addr, 64'h8000_0100);
    tick();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1111_1111;
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t3_hold_valid", {63'h0, if_valid}, 64'd1);
    chk("t3_hold_pc",    if_pc, 64'h8000_0100);
    chk("t3_hold_instu", {32'h0, if_instu}, 64'h1111_1111);

    // 4: redirect and ready together in HOLD; redirect wins, low bits cleared
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    if_ready       = 1'b1;
    #1;
    chk("t4_masked_valid", {63'h0, if_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    #1;
    chk("t4_req",  {63'h0, ireq_valid}, 64'd1);
    chk("t4_addr", ireq_addr, 64'h8000_0100);

    // 5: two redirects before data_ok, last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick();
    redirect_pc    = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    tick();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2222_2222;
    #1;
    chk("t5_addr_held", ireq_addr, 64'h8000_0100);
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t5_dropped", {63'h0, if_valid}, 64'd0);
    chk("t5_addr",    ireq_addr, 64'h8000_0300);
    tick();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0013;
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t5_if_pc",    if_pc, 64'h8000_0300);
    chk("t5_if_instu", {32'h0, if_instu}, 64'h0000_0013);

    // 6: asynchronous reset mid-HOLD, stale response after release ignored
    rst_n = 1'b0;
    #1;
    chk("t6_if_valid", {63'h0, if_valid}, 64'd0);
    chk("t6_if_pc",    if_pc, RST_PC);
    chk("t6_ireq",     {63'h0, ireq_valid}, 64'd0);
    tick();
    rst_n         = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h3333_3333;
    #1;
    chk("t6_no_req_yet", {63'h0, ireq_valid}, 64'd0);
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t6_stale_ignored", {63'h0, if_valid}, 64'd0);
    chk("t6_req",           {63'h0, ireq_valid}, 64'd1);
    chk("t6_addr",          ireq_addr, RST_PC);
    tick();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h4444_4444;
    tick();
    iresp_data_ok = 1'b0;
    #1;
    chk("t6_refetch_pc",    if_pc, RST_PC);
    chk("t6_refetch_instu", {32'h0, if_instu}, 64'h4444_4444);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
